// File: rtl/winograd_acc.sv
// winograd_acc: back-end accumulator for the winograd inner-product array.
// Each accepted beat resolves a carry-save pair, removes the Winograd
// correction term and adds the result into the current tile. A finished tile
// is presented on a valid/ready result port together with a sticky overflow
// flag and a saturating beat count.
module winograd_acc #(
    parameter int OUT_SIZE  = 24,
    parameter int CORR_SIZE = 24,
    parameter int ACC_SIZE  = 32,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [OUT_SIZE-1:0]  psum_0_i,
    input  logic [OUT_SIZE-1:0]  psum_1_i,
    input  logic [CORR_SIZE-1:0] corr_i,
    input  logic                 last_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ACC_SIZE-1:0]  res_o,
    output logic                 ovf_o,
    output logic [CNT_SIZE-1:0]  res_beats_o
);

    // Width in which a single beat term is exact: two sign-extended rows plus
    // the negated correction never need more than two guard bits.
    localparam int TW = ((OUT_SIZE > CORR_SIZE) ? OUT_SIZE : CORR_SIZE) + 2;

    generate
        if (ACC_SIZE < TW) begin : g_acc_too_narrow
            $error("winograd_acc: ACC_SIZE (%0d) must be >= %0d", ACC_SIZE, TW);
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ACC_SIZE-1:0] acc, acc_nxt;
    logic [CNT_SIZE-1:0] beats, beats_nxt;
    logic                sticky_ovf, sticky_nxt;
    logic                active;

    logic                accept;
    logic                load_res;
    logic [TW-1:0]       term;
    logic [ACC_SIZE:0]   term_ext;
    logic [ACC_SIZE-1:0] base;
    logic [ACC_SIZE:0]   sum;
    logic                add_ovf;
    logic [CNT_SIZE-1:0] beats_inc;

    // Beat term in TW bits; every operand is explicitly sign-extended.
    assign term = {{(TW-OUT_SIZE){psum_0_i[OUT_SIZE-1]}}, psum_0_i}
                + {{(TW-OUT_SIZE){psum_1_i[OUT_SIZE-1]}}, psum_1_i}
                - {{(TW-CORR_SIZE){corr_i[CORR_SIZE-1]}}, corr_i};

    assign term_ext = {{(ACC_SIZE+1-TW){term[TW-1]}}, term};

    // An empty accumulator starts from zero so IDLE never depends on stale acc.
    assign base    = (state == IDLE) ? '0 : acc;
    assign sum     = {base[ACC_SIZE-1], base} + term_ext;
    assign add_ovf = sum[ACC_SIZE] ^ sum[ACC_SIZE-1];

    // Saturating beat count; the first beat of a tile always counts as one.
    assign beats_inc = (state == IDLE)   ? CNT_SIZE'(1) :
                       (&beats)          ? beats :
                                           beats + CNT_SIZE'(1);

    // A held, unconsumed result blocks input; a result being consumed this
    // edge does not, so single-beat tiles can stream at full rate.
    assign in_ready_o = active && !flush_i && !(res_valid_o && !res_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Next-state and accumulator update; flush wins over any beat.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise
        // the paths that skip it would infer a latch.
        state_nxt  = state;
        acc_nxt    = acc;
        beats_nxt  = beats;
        sticky_nxt = sticky_ovf;
        load_res   = 1'b0;
        if (flush_i) begin
            state_nxt  = IDLE;
            acc_nxt    = '0;
            beats_nxt  = '0;
            sticky_nxt = 1'b0;
        end else if (accept) begin
            if (last_i) begin
                load_res   = 1'b1;
                state_nxt  = IDLE;
                acc_nxt    = '0;
                beats_nxt  = '0;
                sticky_nxt = 1'b0;
            end else begin
                state_nxt  = ACCUM;
                acc_nxt    = sum[ACC_SIZE-1:0];
                beats_nxt  = beats_inc;
                sticky_nxt = sticky_ovf | add_ovf;
            end
        end
    end

    // Accumulator-side state registers and the post-reset enable flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge regardless of block order.
        if (!rst_ni) begin
            state      <= IDLE;
            acc        <= '0;
            beats      <= '0;
            sticky_ovf <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            beats      <= beats_nxt;
            sticky_ovf <= sticky_nxt;
            active     <= 1'b1;
        end
    end

    // Result register: reload on a last beat, otherwise drop valid once taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the result payload is reset too, because it is visible on the
        // ports and must read zero while reset is asserted.
        if (!rst_ni) begin
            res_valid_o <= 1'b0;
            res_o       <= '0;
            ovf_o       <= 1'b0;
            res_beats_o <= '0;
        end else if (load_res) begin
            res_valid_o <= 1'b1;
            res_o       <= sum[ACC_SIZE-1:0];
            ovf_o       <= sticky_ovf | add_ovf;
            res_beats_o <= beats_inc;
        end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_winograd_acc.sv
// Directed testbench for winograd_acc (ACC_SIZE=26 so overflow is reachable).
module tb_winograd_acc;

    localparam int OUT_W  = 24;
    localparam int CORR_W = 24;
    localparam int ACC_W  = 26;
    localparam int CNT_W  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [OUT_W-1:0]  psum_0_i;
    logic [OUT_W-1:0]  psum_1_i;
    logic [CORR_W-1:0] corr_i;
    logic              last_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [ACC_W-1:0]  res_o;
    logic              ovf_o;
    logic [CNT_W-1:0]  res_beats_o;

    int n_vec = 0;
    int n_err = 0;

    winograd_acc #(
        .OUT_SIZE (OUT_W),
        .CORR_SIZE(CORR_W),
        .ACC_SIZE (ACC_W),
        .CNT_SIZE (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .psum_0_i   (psum_0_i),
        .psum_1_i   (psum_1_i),
        .corr_i     (corr_i),
        .last_i     (last_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_o      (res_o),
        .ovf_o      (ovf_o),
        .res_beats_o(res_beats_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed result port packed as {valid, res, ovf, beats}.
    function automatic logic [ACC_W+CNT_W+1:0] obs();
        return {res_valid_o, res_o, ovf_o, res_beats_o};
    endfunction

    function automatic logic [ACC_W+CNT_W+1:0] exp_res(input logic v, input int r,
                                                        input logic o, input int b);
        return {v, ACC_W'(r), o, CNT_W'(b)};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int p0, input int p1, input int c,
                         input logic l, input logic v);
        psum_0_i   = OUT_W'(p0);
        psum_1_i   = OUT_W'(p1);
        corr_i     = CORR_W'(c);
        last_i     = l;
        in_valid_i = v;
    endtask

    task automatic test_reset();
        logic [ACC_W+CNT_W+1:0] e;
        rst_ni = 1'b0; flush_i = 1'b0; res_ready_i = 1'b1;
        drive(0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        e = exp_res(1'b0, 0, 1'b0, 0);
        if (obs() !== e || in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got %h rdy=%b, want %h rdy=0", obs(), in_ready_o, e);
        end
        n_vec++;
        rst_ni = 1'b1;
        #1;
        if (in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL ready_before_edge: got %b want 0", in_ready_o);
        end
        n_vec++;
        step();
        if (in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL ready_after_release: got %b want 1", in_ready_o);
        end
        n_vec++;
    endtask

    task automatic test_single();
        logic [ACC_W+CNT_W+1:0] e;
        res_ready_i = 1'b1;
        drive(100, -30, 20, 1'b1, 1'b1);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 50, 1'b0, 1);
        if (obs() !== e) begin
            n_err++; $display("FAIL single_result: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
        if (res_valid_o !== 1'b0) begin
            n_err++; $display("FAIL single_valid_drop: got %b want 0", res_valid_o);
        end
        n_vec++;
    endtask

    // Three beats: 12 + (-3) + 14 = 23.
    task automatic test_three_beat();
        logic [ACC_W+CNT_W+1:0] e;
        int p0 [3] = '{10, -4, 7};
        int p1 [3] = '{5, 0, 7};
        int c  [3] = '{3, -1, 0};
        res_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(p0[i], p1[i], c[i], (i == 2), 1'b1);
            if (in_ready_o !== 1'b1) begin
                n_err++; $display("FAIL three_ready_%0d: got %b want 1", i, in_ready_o);
            end
            n_vec++;
            step();
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 23, 1'b0, 3);
        if (obs() !== e) begin
            n_err++; $display("FAIL three_result: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
    endtask

    task automatic test_backpressure();
        logic [ACC_W+CNT_W+1:0] e;
        int p0 [3] = '{10, -4, 7};
        int p1 [3] = '{5, 0, 7};
        int c  [3] = '{3, -1, 0};
        res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(p0[i], p1[i], c[i], (i == 2), 1'b1);
            step();
        end
        // Next tile: single beat with term 3 + 4 - 0 = 7, held under backpressure.
        drive(3, 4, 0, 1'b1, 1'b1);
        e = exp_res(1'b1, 23, 1'b0, 3);
        for (int k = 0; k < 5; k++) begin
            if (obs() !== e || in_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got %h rdy=%b, want %h rdy=0", k, obs(), in_ready_o, e);
            end
            n_vec++;
            step();
        end
        res_ready_i = 1'b1;
        #1;
        if (in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_ready_release: got %b want 1", in_ready_o);
        end
        n_vec++;
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 7, 1'b0, 1);
        if (obs() !== e) begin
            n_err++; $display("FAIL bp_reload: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
        if (res_valid_o !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: got %b want 0", res_valid_o);
        end
        n_vec++;
    endtask

    // Single-beat tiles at full rate: terms 1, 2, 3.
    task automatic test_back_to_back();
        logic [ACC_W+CNT_W+1:0] e;
        res_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(i, 0, 0, 1'b1, 1'b1);
            if (in_ready_o !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready_o);
            end
            n_vec++;
            step();
            e = exp_res(1'b1, i, 1'b0, 1);
            if (obs() !== e) begin
                n_err++; $display("FAIL b2b_result_%0d: got %h want %h", i, obs(), e);
            end
            n_vec++;
        end
        drive(0, 0, 0, 1'b0, 1'b0);
    endtask

    // 2 x 25165822 = 50331644 wraps in 26 bits to -16777220.
    task automatic test_overflow();
        logic [ACC_W+CNT_W+1:0] e;
        res_ready_i = 1'b1;
        drive(8388607, 8388607, -8388608, 1'b0, 1'b1);
        step();
        if (res_valid_o !== 1'b0) begin
            n_err++; $display("FAIL ovf_first_beat_valid: got %b want 0", res_valid_o);
        end
        n_vec++;
        drive(8388607, 8388607, -8388608, 1'b1, 1'b1);
        step();
        drive(5, 0, 0, 1'b1, 1'b1);
        e = exp_res(1'b1, -16777220, 1'b1, 2);
        if (obs() !== e) begin
            n_err++; $display("FAIL ovf_result: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 5, 1'b0, 1);
        if (obs() !== e) begin
            n_err++; $display("FAIL ovf_clean_next: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
    endtask

    task automatic test_flush();
        logic [ACC_W+CNT_W+1:0] e;
        res_ready_i = 1'b1;
        drive(40, 0, 0, 1'b0, 1'b1);
        step();
        flush_i = 1'b1;
        drive(7, 0, 0, 1'b1, 1'b1);
        #1;
        if (in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL flush_ready: got %b want 0", in_ready_o);
        end
        n_vec++;
        step();
        flush_i = 1'b0;
        if (res_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush_no_consume: got %b want 0", res_valid_o);
        end
        n_vec++;
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 7, 1'b0, 1);
        if (obs() !== e) begin
            n_err++; $display("FAIL flush_result: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
    endtask

    // 300 beats of term 1: count saturates at 255, sum stays exact.
    task automatic test_saturate();
        logic [ACC_W+CNT_W+1:0] e;
        res_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 0, (i == 299), 1'b1);
            step();
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        e = exp_res(1'b1, 300, 1'b0, 255);
        if (obs() !== e) begin
            n_err++; $display("FAIL saturate_result: got %h want %h", obs(), e);
        end
        n_vec++;
        step();
    endtask

    task automatic test_reset_held();
        res_ready_i = 1'b0;
        drive(9, 0, 0, 1'b1, 1'b1);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        if (res_valid_o !== 1'b1 || res_o !== ACC_W'(9)) begin
            n_err++; $display("FAIL held_before_reset: got v=%b r=%0d want v=1 r=9", res_valid_o, res_o);
        end
        n_vec++;
        #2;
        rst_ni = 1'b0;
        #1;
        if (res_valid_o !== 1'b0 || res_o !== '0 || in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got v=%b r=%0d rdy=%b want 0/0/0", res_valid_o, res_o, in_ready_o);
        end
        n_vec++;
        step();
        rst_ni = 1'b1;
        res_ready_i = 1'b1;
        #1;
        if (in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 0", in_ready_o);
        end
        n_vec++;
        step();
        if (in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_return: got %b want 1", in_ready_o);
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_beat();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_saturate();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/winograd_acc.md
# winograd_acc

Back-end consumer for the `winograd` fast inner-product array. Each accepted beat carries one carry-save result pair and the matching Winograd correction term (Σ in_0[2j]·in_0[2j+1] + Σ in_1[2j]·in_1[2j+1], precomputed upstream). The block resolves the pair, subtracts the correction, and accumulates beats into one dot-product tile. It emits each finished tile through a valid/ready result port with an overflow flag and a beat count.

## Interface
- OUT_SIZE, 24: width of each carry-save row from `winograd`.
- CORR_SIZE, 24: width of the signed correction term.
- ACC_SIZE, 32: accumulator and result width. Must be ≥ TW = max(OUT_SIZE, CORR_SIZE) + 2, checked by an elaboration assertion.
- CNT_SIZE, 8: width of the beat counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of the tile being accumulated.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat ready.
- psum_0_i  in  OUT_SIZE  carry-save row 0, signed.
- psum_1_i  in  OUT_SIZE  carry-save row 1, signed.
- corr_i  in  CORR_SIZE  correction term, signed.
- last_i  in  1  beat closes the tile.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_o  out  ACC_SIZE  tile dot product, signed two's complement.
- ovf_o  out  1  tile overflowed ACC_SIZE.
- res_beats_o  out  CNT_SIZE  beats in the tile, saturating.

## Operation
- Beat term = sext(psum_0_i) + sext(psum_1_i) − sext(corr_i), computed in TW bits. This term is exact.
- A beat is accepted on a rising edge where in_valid_i && in_ready_o.
- in_ready_o = active && !flush_i && !(res_valid_o && !res_ready_i).
  - `active` is a flop, cleared by reset and set on the first edge after rst_ni deasserts.
- State machine (accumulator side):
  - IDLE: acc empty.
  - ACCUM: tile in progress.
  - Accepted beat with !last_i: next acc = (IDLE ? 0 : acc) + term; beats = (IDLE ? 1 : beats+1); go to ACCUM.
  - Accepted beat with last_i: res_o ← (IDLE ? 0 : acc) + term; res_beats_o ← (IDLE ? 1 : beats+1); ovf_o ← sticky_ovf | ovf of this add; res_valid_o ← 1; go to IDLE; acc, beats and sticky_ovf cleared.
  - flush_i: acc, beats and sticky_ovf cleared, go to IDLE; no beat is consumed that cycle. flush_i has priority over everything on the accumulator side. It does not touch a held result.
- Arithmetic width and overflow:
  - Addition is performed in ACC_SIZE+1 bits.
  - Overflow is flagged when the two top bits differ.
  - The stored value is the low ACC_SIZE bits (wrap).
  - Overflow is sticky per tile.
- Beat counter saturates at 2^CNT_SIZE − 1. Saturation does not affect arithmetic.
- Result register:
  - res_valid_o clears on an edge with res_valid_o && res_ready_i, unless a last beat is accepted on the same edge, in which case it reloads and stays 1.
  - res_o, ovf_o and res_beats_o hold stable while res_valid_o && !res_ready_i.

## Timing
- Reset (async, immediate): res_valid_o=0, res_o=0, ovf_o=0, res_beats_o=0, in_ready_o=0, state IDLE, acc=0.
- in_ready_o rises one cycle after rst_ni deasserts.
- Latency: last beat accepted at edge N → res_valid_o=1 from edge N.
- Throughput: one beat per cycle, including back-to-back single-beat tiles while res_ready_i=1.
- Backpressure:
  - While a result is held unaccepted, in_ready_o=0.
  - A beat presented in that state waits; in_valid_i and the payload must hold.
- Simultaneous result handshake and last-beat accept on the same edge: the old result is consumed, the new one is loaded, and res_valid_o stays 1.
- Reset mid-tile or with a held result: all state is lost and outputs go to reset values.

## Test plan
- Single-beat tile: psum_0=100, psum_1=−30, corr=20, last=1, res_ready=1 → at the accept edge res_o=50, ovf_o=0, res_beats_o=1; res_valid_o high for one cycle.
- Three-beat tile, back-to-back:
  - Beats (psum_0, psum_1, corr) = (10,5,3), (−4,0,−1), (7,7,0), last on the third.
  - Required: res_o=23, res_beats_o=3, in_ready_o=1 throughout.
- Backpressure:
  - Complete a tile with res_o=23 while res_ready=0.
  - Required: in_ready_o drops; res_o stays 23 for 5 cycles while the next beat is held.
  - Raise res_ready → result consumed; the held beat is accepted on the same edge.
- Overflow, ACC_SIZE=26:
  - Two beats of psum_0=psum_1=8388607, corr=−8388608 (term 25165822 each), last on the second.
  - Required: res_o=−16777220, ovf_o=1.
  - The following clean tile reports ovf_o=0.
- Flush mid-tile:
  - Beat with term 40, then flush_i=1 for one cycle with in_valid_i=1 (beat not consumed).
  - Then a beat with term 7 and last=1.
  - Required: res_o=7, res_beats_o=1.
- Reset with a held result: drive rst_ni=0 while res_valid_o=1 → res_valid_o, res_o and in_ready_o go to 0 immediately; in_ready_o returns to 1 one cycle after release.
